mux_arb: RTL and testbench



---
 rtl/mux_arb.sv | 118 +++++++++++
 tb/tb_mux_arb.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mux_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mux_arb : registered N-channel selector, fixed-priority or round-robin.  |
// | Optional: MUX_ARB_SVA_EN compiles in the protocol assertions.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mux_arb #(
  parameter int WIDTH  = 4,
  parameter int NUM_CH = 3,
  localparam int CW    = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NUM_CH*WIDTH-1:0] ip,
  input  logic [NUM_CH-1:0]       sel,
  input  logic                    rr_mode,
  input  logic                    hold,
  output logic [WIDTH-1:0]        mux_op,
  output logic                    op_valid,
  output logic [NUM_CH-1:0]       grant,
  output logic [CW-1:0]           grant_id
);

  localparam logic [CW-1:0]     c_last_init = CW'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] c_one       = NUM_CH'(1);

  logic [WIDTH-1:0]  r_mux;
  logic              r_valid;
  logic [NUM_CH-1:0] r_grant;
  logic [CW-1:0]     r_gid;
  logic [CW-1:0]     r_last;

  logic [CW-1:0]     w_win;
  logic [CW-1:0]     w_idx;
  logic              w_found;
  logic              w_any;
  logic [WIDTH-1:0]  w_data;
  int                w_pos;

  assign w_any = |sel;

  always_comb begin
    w_win   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    w_pos   = 0;
    if (!rr_mode) begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        w_idx = CW'(k);
        if (sel[w_idx]) w_win = w_idx;
      end
    end else begin
      // Search starts one past the previous winner and wraps.
      for (int n = 1; n <= NUM_CH; n++) begin
        w_pos = int'(r_last) + n;
        if (w_pos >= NUM_CH) w_pos = w_pos - NUM_CH;
        w_idx = CW'(w_pos);
        if (!w_found && sel[w_idx]) begin
          w_win   = w_idx;
          w_found = 1'b1;
        end
      end
    end
  end

  // Only the winning lane is read, so X on idle lanes cannot reach mux_op.
  assign w_data = ip[int'(w_win)*WIDTH +: WIDTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mux   <= '0;
      r_valid <= 1'b0;
      r_grant <= '0;
      r_gid   <= '0;
      r_last  <= c_last_init;
    end else if (!hold) begin
      if (w_any) begin
        r_mux   <= w_data;
        r_valid <= 1'b1;
        r_grant <= c_one << w_win;
        r_gid   <= w_win;
        r_last  <= w_win;
      end else begin
        r_valid <= 1'b0;
        r_grant <= '0;
      end
    end
  end

  assign mux_op   = r_mux;
  assign op_valid = r_valid;
  assign grant    = r_grant;
  assign grant_id = r_gid;

`ifdef MUX_ARB_SVA_EN
  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_sva_prio
      localparam logic [NUM_CH-1:0] c_lower = NUM_CH'((1 << k) - 1);
      a_prio: assert property (@(posedge clock) disable iff (!reset_n)
        (!rr_mode && !hold && sel[k] && ((sel & c_lower) == '0)) |=>
          (mux_op == $past(ip[k*WIDTH +: WIDTH])) && (int'(grant_id) == k));
    end
  endgenerate

  a_onehot: assert property (@(posedge clock) disable iff (!reset_n)
    $onehot0(grant));
  a_valid: assert property (@(posedge clock) disable iff (!reset_n)
    op_valid == |grant);
  a_hold: assert property (@(posedge clock) disable iff (!reset_n)
    hold |=> $stable({mux_op, op_valid, grant, grant_id}));
  // op_valid guarantees grant_id and the RR pointer agree.
  a_rr: assert property (@(posedge clock) disable iff (!reset_n)
    (rr_mode && !hold && (&sel) && op_valid) |=>
      int'(grant_id) == (int'($past(grant_id)) + 1) % NUM_CH);
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_arb.sv
`default_nettype none
// Directed bench for mux_arb with a behavioural reference model.
module tb_mux_arb;

  localparam int W  = 4;
  localparam int N  = 3;
  localparam int CW = 2;

  logic          clock;
  logic          reset_n;
  logic [N*W-1:0] ip;
  logic [N-1:0]  sel;
  logic          rr_mode;
  logic          hold;
  logic [W-1:0]  mux_op;
  logic          op_valid;
  logic [N-1:0]  grant;
  logic [CW-1:0] grant_id;

  int n_checks = 0;
  int n_fail   = 0;

  mux_arb #(.WIDTH(W), .NUM_CH(N)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .ip       (ip),
    .sel      (sel),
    .rr_mode  (rr_mode),
    .hold     (hold),
    .mux_op   (mux_op),
    .op_valid (op_valid),
    .grant    (grant),
    .grant_id (grant_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: expected registered outputs.
  logic [W-1:0] m_mux;
  logic         m_valid;
  int           m_gid;
  int           m_last;

  function automatic int pick(input logic rr, input logic [N-1:0] s, input int last);
    if (!rr) begin
      for (int c = 0; c < N; c++) if (s[c]) return c;
    end else begin
      for (int n = 1; n <= N; n++) if (s[(last + n) % N]) return (last + n) % N;
    end
    return -1;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_mux = '0; m_valid = 1'b0; m_gid = 0; m_last = N - 1;
    end else if (!hold) begin
      if (sel != '0) begin
        m_gid   = pick(rr_mode, sel, m_last);
        m_last  = m_gid;
        m_mux   = ip[m_gid*W +: W];
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    logic [N-1:0] eg;
    eg = m_valid ? (N'(1) << m_gid) : '0;
    chk("model_mux_op", 32'(mux_op), 32'(m_mux));
    chk("model_op_valid", 32'(op_valid), 32'(m_valid));
    chk("model_grant", 32'(grant), 32'(eg));
    chk("model_grant_id", 32'(grant_id), 32'(m_gid));
    chk("valid_eq_or_grant", 32'(op_valid), 32'(|grant));
  end

  task automatic step(input logic [N-1:0] s, input logic [N*W-1:0] d,
                      input logic rr, input logic h);
    sel = s; ip = d; rr_mode = rr; hold = h;
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [W-1:0] m, input logic v,
                            input logic [N-1:0] g, input logic [CW-1:0] id);
    chk({name, "_mux_op"}, 32'(mux_op), 32'(m));
    chk({name, "_op_valid"}, 32'(op_valid), 32'(v));
    chk({name, "_grant"}, 32'(grant), 32'(g));
    chk({name, "_grant_id"}, 32'(grant_id), 32'(id));
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #1;
    expect_out("async_reset", 4'h0, 1'b0, 3'b000, 2'd0);
    #1;
    reset_n = 1'b1;
  endtask

  localparam logic [N*W-1:0] c_cba = {4'hC, 4'hB, 4'hA};

  initial begin
    logic [CW-1:0] rr_ids [6];
    logic [W-1:0]  rr_dat [6];
    rr_ids = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    rr_dat = '{4'hA, 4'hB, 4'hC, 4'hA, 4'hB, 4'hC};

    reset_n = 1'b0; sel = '0; ip = '0; rr_mode = 1'b0; hold = 1'b0;
    @(posedge clock); @(posedge clock); #1;
    expect_out("reset", 4'h0, 1'b0, 3'b000, 2'd0);
    reset_n = 1'b1;

    // Mid-stream reset, then RR restarts at channel 0.
    step(3'b111, c_cba, 1'b1, 1'b0);
    step(3'b111, c_cba, 1'b1, 1'b0);
    step(3'b111, c_cba, 1'b1, 1'b0);
    expect_out("rr_pre_reset", 4'hC, 1'b1, 3'b100, 2'd2);
    pulse_reset();
    step(3'b111, c_cba, 1'b1, 1'b0);
    expect_out("rr_after_reset", 4'hA, 1'b1, 3'b001, 2'd0);

    // Fixed priority.
    step(3'b110, c_cba, 1'b0, 1'b0);
    expect_out("priority", 4'hB, 1'b1, 3'b010, 2'd1);

    // Round-robin rotation with all requesters.
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      step(3'b111, c_cba, 1'b1, 1'b0);
      chk("rr_seq_grant_id", 32'(grant_id), 32'(rr_ids[i]));
      chk("rr_seq_mux_op", 32'(mux_op), 32'(rr_dat[i]));
    end

    // Skip and wrap.
    step(3'b010, c_cba, 1'b1, 1'b0);
    chk("rr_skip1", 32'(grant_id), 32'd1);
    step(3'b101, c_cba, 1'b1, 1'b0);
    chk("rr_skip2", 32'(grant_id), 32'd2);
    step(3'b101, c_cba, 1'b1, 1'b0);
    chk("rr_wrap", 32'(grant_id), 32'd0);

    // Idle keeps data and grant_id.
    step(3'b100, c_cba, 1'b0, 1'b0);
    expect_out("load_c", 4'hC, 1'b1, 3'b100, 2'd2);
    step(3'b000, c_cba, 1'b0, 1'b0);
    expect_out("idle", 4'hC, 1'b0, 3'b000, 2'd2);

    // Hold freezes outputs and RR pointer.
    step(3'b001, c_cba, 1'b1, 1'b0);
    expect_out("pre_hold", 4'hA, 1'b1, 3'b001, 2'd0);
    step(3'b001, {4'h3, 4'h2, 4'h1}, 1'b1, 1'b1);
    expect_out("hold1", 4'hA, 1'b1, 3'b001, 2'd0);
    step(3'b000, {4'h6, 4'h5, 4'h4}, 1'b1, 1'b1);
    expect_out("hold2", 4'hA, 1'b1, 3'b001, 2'd0);
    step(3'b111, {4'hF, 4'hE, 4'hD}, 1'b1, 1'b0);
    expect_out("resume", 4'hE, 1'b1, 3'b010, 2'd1);

    // X on unselected lanes.
    step(3'b001, {4'bxxxx, 4'bxxxx, 4'h5}, 1'b0, 1'b0);
    expect_out("x_lanes", 4'h5, 1'b1, 3'b001, 2'd0);

    step(3'b000, c_cba, 1'b0, 1'b0);
    @(negedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
